// File: rtl/ro_sum_accumulator_pkg.sv
// Shared types and constants for the ring-oscillator sum accumulator.
// Optional build macro: SUM_SATURATE_EN (saturating 24-bit accumulation; wraps when undefined).
package ro_sum_accumulator_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int ACC_W = 24;

  localparam logic [1:0] SEL_BYTE_HI  = 2'd0;
  localparam logic [1:0] SEL_BYTE_MID = 2'd1;
  localparam logic [1:0] SEL_BYTE_LO  = 2'd2;
  localparam logic [1:0] SEL_NONE     = 2'd3;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SUM_SATURATE_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/ro_sum_accumulator_edge_sync.sv
// 2-FF synchronizer plus registered rising-edge detector for the ring-oscillator input.
module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      sync_2_d   <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_1     <= async_in;
      sync_2     <= sync_1;
      sync_2_d   <= sync_2;
      edge_pulse <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/ro_sum_accumulator.sv
// Counts ring-oscillator edges per gate window and accumulates NUM_SAMPLES windows into a 24-bit sum.
// Optional build macro: SUM_SATURATE_EN (see package acc_add).
module ro_sum_accumulator
  import ro_sum_accumulator_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int NUM_SAMPLES   = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_in,
  input  logic             sum_en,
  input  logic [1:0]       send_sel,
  output logic [ACC_W-1:0] sum,
  output logic             sum_ready,
  output logic [7:0]       tx_data
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [TW-1:0]    WIN_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [SW-1:0]    IDX_LAST = SW'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic             ro_edge;
  logic [TW-1:0]    win_timer;
  logic [CNT_W-1:0] edge_cnt;
  logic [SW-1:0]    sample_idx;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] win_val;
  logic [ACC_W-1:0] win_ext;
  logic             win_end;
  logic             last_win;
  logic             counting;
  logic             complete;

  ro_edge_sync u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (ro_in),
    .edge_pulse(ro_edge)
  );

  assign win_end  = (win_timer == WIN_LAST);
  assign last_win = (sample_idx == IDX_LAST);
  assign win_val  = (ro_edge && edge_cnt != CNT_MAX) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign win_ext  = ACC_W'(win_val);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A completion on the final window-end cycle wins over sum_en falling.
  always_comb begin
    state_next = state;
    counting   = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sum_en) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        counting = sum_en;
        complete = win_end && last_win;
        if (!sum_en) state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !counting) begin
      win_timer  <= '0;
      edge_cnt   <= '0;
      sample_idx <= '0;
      acc        <= '0;
    end else if (win_end) begin
      win_timer <= '0;
      edge_cnt  <= '0;
      if (last_win) begin
        sample_idx <= '0;
        acc        <= '0;
      end else begin
        sample_idx <= sample_idx + SW'(1);
        acc        <= acc_add(acc, win_ext);
      end
    end else begin
      win_timer <= win_timer + TW'(1);
      if (ro_edge && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      sum_ready <= 1'b0;
    end else begin
      sum_ready <= complete;
      if (complete) sum <= acc_add(acc, win_ext);
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (send_sel)
      SEL_BYTE_HI:  tx_data = sum[23:16];
      SEL_BYTE_MID: tx_data = sum[15:8];
      SEL_BYTE_LO:  tx_data = sum[7:0];
      SEL_NONE:     tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ro_sum_accumulator.sv
// Self-checking bench for ro_sum_accumulator against a window-counting reference model.
module tb_ro_sum_accumulator;

  localparam int WC  = 100;
  localparam int NS  = 4;
  localparam int NW  = WC * NS;
  localparam int SWC = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        ro_in;
  logic        sum_en;
  logic        sat_en;
  logic [1:0]  send_sel;
  logic [23:0] sum;
  logic        sum_ready;
  logic [7:0]  tx_data;
  logic [23:0] sat_sum;
  logic        sat_ready;
  logic [7:0]  sat_tx;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          edges[$];
  logic [23:0] held_sum;
  bit          ro_quiet;
  bit          ro_rand;
  int          ro_hi;
  int          ro_lo;
  int          ro_left;

  ro_sum_accumulator #(.WINDOW_CYCLES(WC), .NUM_SAMPLES(NS), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .sum_en(sum_en), .send_sel(send_sel),
    .sum(sum), .sum_ready(sum_ready), .tx_data(tx_data)
  );

  ro_sum_accumulator #(.WINDOW_CYCLES(SWC), .NUM_SAMPLES(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ro_in(ro_in), .sum_en(sat_en), .send_sel(send_sel),
    .sum(sat_sum), .sum_ready(sat_ready), .tx_data(sat_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // A rise driven after posedge c is seen by the FSM at posedge c+4 (2 sync + detect + use).
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (ro_quiet) begin
      ro_in   = 1'b0;
      ro_left = 0;
    end else begin
      if (ro_left > 0) ro_left--;
      if (ro_left == 0) begin
        ro_in = ~ro_in;
        if (ro_in) edges.push_back(cyc + 4);
        ro_left = ro_rand ? int'($urandom_range(2, 6)) : (ro_in ? ro_hi : ro_lo);
      end
    end
  endtask

  function automatic int count_edges(input int lo, input int hi);
    int c = 0;
    foreach (edges[i]) if (edges[i] >= lo && edges[i] <= hi) c++;
    return c;
  endfunction

  function automatic logic [23:0] add24(input logic [23:0] a, input int v);
    longint s;
    s = longint'(a) + longint'(v);
`ifdef SUM_SATURATE_EN
    if (s > 64'hFFFFFF) s = 64'hFFFFFF;
`endif
    return s[23:0];
  endfunction

  function automatic logic [23:0] model_sum(input int k, input int run, input int wc,
                                            input int ns, input int cmax);
    logic [23:0] a = '0;
    int v;
    for (int j = run * ns; j < (run + 1) * ns; j++) begin
      v = count_edges(k + 1 + j * wc, k + (j + 1) * wc);
      if (v > cmax) v = cmax;
      a = add24(a, v);
    end
    return a;
  endfunction

  function automatic logic [7:0] byte_of(input logic [23:0] v, input int s);
    case (s)
      0: return v[23:16];
      1: return v[15:8];
      2: return v[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // drop_off > 0: sum_en sampled low at k+drop_off; otherwise held for 'runs' completions.
  task automatic measure(input string name, input int runs, input int drop_off);
    int k, d, off, stray;
    logic [23:0] exp;
    d = (drop_off > 0) ? drop_off : runs * NW + 1;
    stray = 0;
    sum_en = 1'b1;
    k = cyc + 1;
    while (cyc < k + d) begin
      step();
      if (cyc == k + d - 1) sum_en = 1'b0;
      off = cyc - k;
      if (off > 0 && off % NW == 0) begin
        exp = model_sum(k, off / NW - 1, WC, NS, 65535);
        checks++;
        if (sum_ready !== 1'b1 || sum !== exp) begin
          errors++;
          $display("FAIL %s pulse at +%0d: ready=%b sum=%h expected ready=1 sum=%h",
                   name, off, sum_ready, sum, exp);
        end
        held_sum = exp;
      end else if (sum_ready !== 1'b0) begin
        stray++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (sum_ready !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL %s stray pulses: got %0d expected 0", name, stray);
    end
    checks++;
    if (sum !== held_sum) begin
      errors++;
      $display("FAIL %s held sum: got %h expected %h", name, sum, held_sum);
    end
    for (int s = 0; s < 4; s++) begin
      send_sel = 2'(s);
      #1;
      checks++;
      if (tx_data !== byte_of(held_sum, s)) begin
        errors++;
        $display("FAIL %s tx_data sel %0d: got %h expected %h", name, s, tx_data,
                 byte_of(held_sum, s));
      end
    end
  endtask

  task automatic check_sum_const(input string name, input logic [23:0] exp);
    checks++;
    if (sum !== exp) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, sum, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    held_sum = '0;
    checks++;
    if (sum !== 24'h0 || sum_ready !== 1'b0 || sat_sum !== 24'h0 || sat_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: sum=%h ready=%b sat_sum=%h sat_ready=%b expected zeros",
               sum, sum_ready, sat_sum, sat_ready);
    end
    for (int s = 0; s < 4; s++) begin
      send_sel = 2'(s);
      #1;
      checks++;
      if (tx_data !== 8'h00) begin
        errors++;
        $display("FAIL reset tx_data sel %0d: got %h expected 00", s, tx_data);
      end
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    ro_quiet = 0; ro_rand = 0; ro_hi = 5; ro_lo = 5;
    for (int i = 0; i < 30; i++) step();
    measure("basic", 2, -1);
    check_sum_const("basic_const", 24'h000028);
    send_sel = 2'd2;
    #1;
    checks++;
    if (tx_data !== 8'h28) begin
      errors++;
      $display("FAIL basic tx lo byte: got %h expected 28", tx_data);
    end
  endtask

  task automatic test_abort();
    measure("abort", 1, 250);
    check_sum_const("abort_held", 24'h000028);
    for (int i = 0; i < int'($urandom_range(1, 20)); i++) step();
    measure("rerun", 1, -1);
    check_sum_const("rerun_const", 24'h000028);
  endtask

  task automatic test_cnt_sat();
    int k;
    logic [23:0] exp;
    ro_hi = 2; ro_lo = 3;
    for (int i = 0; i < 20; i++) step();
    sat_en = 1'b1;
    k = cyc + 1;
    while (cyc < k + SWC) step();
    exp = model_sum(k, 0, SWC, 1, 15);
    checks++;
    if (sat_ready !== 1'b1 || sat_sum !== 24'd15 || sat_sum !== exp) begin
      errors++;
      $display("FAIL cnt_sat: ready=%b sum=%h expected ready=1 sum=%h (model %h)",
               sat_ready, sat_sum, 24'd15, exp);
    end
    send_sel = 2'd2;
    #1;
    checks++;
    if (sat_tx !== 8'h0F) begin
      errors++;
      $display("FAIL cnt_sat tx: got %h expected 0f", sat_tx);
    end
    sat_en = 1'b0;
    step();
    ro_hi = 5; ro_lo = 5;
  endtask

  task automatic test_reset_mid();
    sum_en = 1'b1;
    for (int i = 0; i < 150; i++) step();
    ro_quiet = 1;
    for (int i = 0; i < 5; i++) step();
    sum_en = 1'b0;
    reset  = 1'b1;
    step();
    held_sum = '0;
    send_sel = 2'd2;
    #1;
    checks++;
    if (sum !== 24'h0 || sum_ready !== 1'b0 || tx_data !== 8'h00 || sat_sum !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid: sum=%h ready=%b tx=%h sat_sum=%h expected zeros",
               sum, sum_ready, tx_data, sat_sum);
    end
    reset = 1'b0;
    ro_quiet = 0;
    for (int i = 0; i < 30; i++) step();
    measure("after_reset", 1, -1);
    check_sum_const("after_reset_const", 24'h000028);
  endtask

  task automatic test_late_fall();
    int stray = 0;
    for (int i = 0; i < 7; i++) step();
    measure("late_fall", 1, NW);
    check_sum_const("late_fall_const", 24'h000028);
    for (int i = 0; i < NW + 20; i++) begin
      step();
      if (sum_ready !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL late_fall idle pulses: got %0d expected 0", stray);
    end
  endtask

  task automatic test_random();
    int runs, drop;
    ro_rand = 1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < int'($urandom_range(0, 30)); i++) step();
      runs = int'($urandom_range(1, 2));
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, runs * NW)) : -1;
      measure($sformatf("random%0d", it), runs, drop);
    end
  endtask

  initial begin
    reset = 1'b1; ro_in = 1'b0; sum_en = 1'b0; sat_en = 1'b0; send_sel = 2'd0;
    ro_quiet = 1; ro_rand = 0; ro_hi = 5; ro_lo = 5; ro_left = 0;
    held_sum = '0;
    test_reset();
    test_basic();
    test_abort();
    test_cnt_sat();
    test_reset_mid();
    test_late_fall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
